ram_access_ctrl: RTL

- Request/response front end for the single-port 32-bit synchronous RAM. The RAM has 1-cycle registered read latency, and its read-data output is high-Z unless read or write-enable is held.
- Accepts single-beat write requests and incrementing read bursts from the datapath over a valid/ready request channel.
- Sequences the RAM's read and write-enable controls and captures read data while the RAM output is driven.
- Returns read beats over a valid/ready response channel with backpressure.

---
 rtl/ram_access_ctrl.sv | 130 +++++++++++++
 1 files changed

// File: rtl/ram_access_ctrl.sv
// ram_access_ctrl
// Request/response front end for a single-port 32-bit synchronous RAM with a
// 1-cycle registered read. It accepts single-beat writes and incrementing
// read bursts, drives the RAM controls, captures read data while the RAM
// output is driven, and returns read beats with backpressure.
//
// Ports:
//   clk, rst_n                 clock (rising edge), async active-low reset
//   req_valid/req_ready        request handshake
//   req_we, req_addr,          1 = write / 0 = read burst, start address,
//   req_wdata, req_len         write data, read beats minus 1
//   resp_valid/resp_ready      response handshake
//   resp_data, resp_last       read beat, final beat of the burst
//   wr_done                    one-cycle pulse after a write commits
//   ram_addr, ram_din,         RAM address, write data,
//   ram_we, ram_read           write enable, read enable
//   ram_dout                   RAM read data (high-Z when not read/written)
//
// state      | meaning
// -----------+--------------------------------------------------------------
// S_IDLE     | waiting for a request; req_ready=1
// S_WR       | ram_we=1 for one cycle; RAM commits at the ending edge
// S_RD_ISSUE | ram_read=1; RAM registers mem[ram_addr] at the ending edge
// S_RD_CAPT  | ram_read held so ram_dout is driven; beat captured at the edge
// S_RD_RESP  | beat presented on resp_*; waits for resp_ready
module ram_access_ctrl #(
  parameter int ADDR_WIDTH = 8,
  parameter int LEN_WIDTH  = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [31:0]           req_wdata,
  input  logic [LEN_WIDTH-1:0]  req_len,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [31:0]           resp_data,
  output logic                  resp_last,
  output logic                  wr_done,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [31:0]           ram_din,
  output logic                  ram_we,
  output logic                  ram_read,
  input  logic [31:0]           ram_dout
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WR,
    S_RD_ISSUE,
    S_RD_CAPT,
    S_RD_RESP
  } state_t;

  state_t                state_q;
  state_t                state_d;
  logic [LEN_WIDTH-1:0]  remain_q;
  logic                  accept;
  logic                  resp_hs;

  // Gating with rst_n keeps req_ready low while reset is held even though the
  // state register already reads IDLE.
  assign req_ready = (state_q == S_IDLE) && rst_n;
  assign ram_we    = (state_q == S_WR);
  assign ram_read  = (state_q == S_RD_ISSUE) || (state_q == S_RD_CAPT);
  assign accept    = req_valid && req_ready;
  assign resp_hs   = resp_valid && resp_ready;

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          state_d = req_we ? S_WR : S_RD_ISSUE;
        end
      end
      S_WR:       state_d = S_IDLE;
      S_RD_ISSUE: state_d = S_RD_CAPT;
      S_RD_CAPT:  state_d = S_RD_RESP;
      S_RD_RESP: begin
        if (resp_hs) begin
          state_d = (remain_q == '0) ? S_IDLE : S_RD_ISSUE;
        end
      end
      default:    state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      remain_q   <= '0;
      ram_addr   <= '0;
      ram_din    <= '0;
      resp_valid <= 1'b0;
      resp_last  <= 1'b0;
      resp_data  <= '0;
      wr_done    <= 1'b0;
    end else begin
      state_q <= state_d;
      wr_done <= (state_q == S_WR);

      // ram_addr doubles as the current burst address.
      if (accept) begin
        ram_addr <= req_addr;
        ram_din  <= req_wdata;
        remain_q <= req_len;
      end

      if (state_q == S_RD_CAPT) begin
        resp_data  <= ram_dout;
        resp_valid <= 1'b1;
        resp_last  <= (remain_q == '0);
      end

      if ((state_q == S_RD_RESP) && resp_hs) begin
        resp_valid <= 1'b0;
        resp_last  <= 1'b0;
        if (remain_q != '0) begin
          remain_q <= remain_q - LEN_WIDTH'(1);
          ram_addr <= ram_addr + ADDR_WIDTH'(1);
        end
      end
    end
  end

endmodule
